// File: rtl/game_pkg.sv
// Shared types, the board line table and the win detector for the 3x3 selection game.
// Pure combinational helpers; no state and no flow control.
package game_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        PLAY,
        WIN,
        DRAW
    } state_t;

    localparam int NUM_CELLS = 9;

    localparam logic [3:0] LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    function automatic cell_t line_winner(input logic [2*NUM_CELLS-1:0] b);
        cell_t      w;
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        w = EMPTY;
        for (int l = 0; l < 8; l++) begin
            c0 = b[2*LINES[l][0] +: 2];
            c1 = b[2*LINES[l][1] +: 2];
            c2 = b[2*LINES[l][2] +: 2];
            if (c0 != 2'b00 && c0 == c1 && c0 == c2) begin
                w = cell_t'(c0);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/game_controller_button_conditioner.sv
// Synchronises and debounces one raw pushbutton, emitting one pulse per accepted press.
// Pulse arrives 2 + DEBOUNCE_CYCLES cycles after a clean edge; no backpressure, pulses are fire-and-forget.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        // Any sample agreeing with the accepted level restarts the stability run.
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync2_q;
            pulse_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/game_controller.sv
// Runs the 3x3 game: cursor, board marks, per-turn timer and win/draw detection.
// Board/state update on the edge after a button pulse; inputs are never stalled.
module game_controller
    import game_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TURN_SECONDS    = 30,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        move,
    input  logic        select,
    output logic [3:0]  selected,
    output logic [17:0] board,
    output logic        player,
    output logic [4:0]  seconds_left,
    output logic        counting,
    output logic        finish,
    output logic        finish_30sec,
    output logic [1:0]  winner
);

    localparam int         PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [4:0] SECS_RELOAD = 5'(TURN_SECONDS);

    logic          mv_p, sel_p;
    logic [3:0]    selected_q, selected_d;
    logic [17:0]   board_q, board_d;
    logic          player_q, player_d;
    logic [4:0]    secs_q, secs_d;
    logic [PW-1:0] presc_q, presc_d;
    state_t        state_q, state_d;
    logic [1:0]    winner_q, winner_d;
    logic          f30_q, f30_d;
    logic          tick, accept, board_full;
    logic [1:0]    cur_cell;
    cell_t         win_mark;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_move_cond (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .raw      (move),
        .pulse    (mv_p)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_select_cond (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .raw      (select),
        .pulse    (sel_p)
    );

    always_comb begin
        selected_d = selected_q;
        board_d    = board_q;
        player_d   = player_q;
        secs_d     = secs_q;
        presc_d    = presc_q;
        state_d    = state_q;
        winner_d   = winner_q;
        f30_d      = 1'b0;
        tick       = 1'b0;
        accept     = 1'b0;
        board_full = 1'b1;
        cur_cell   = 2'b00;
        win_mark   = EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (selected_q == 4'(i)) cur_cell = board_q[2*i +: 2];
        end
        if (state_q == PLAY) begin
            tick    = (presc_q == PW'(CLK_HZ - 1));
            presc_d = tick ? '0 : presc_q + PW'(1);
            accept  = sel_p && (cur_cell == EMPTY);
            // An accepted mark ends the turn, so it pre-empts a coincident timeout.
            if (accept) begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    if (selected_q == 4'(i)) board_d[2*i +: 2] = player_q ? P2 : P1;
                end
                player_d = ~player_q;
                secs_d   = SECS_RELOAD;
                presc_d  = '0;
            end else if (tick) begin
                if (secs_q == 5'd1) begin
                    f30_d    = 1'b1;
                    player_d = ~player_q;
                    secs_d   = SECS_RELOAD;
                end else begin
                    secs_d = secs_q - 5'd1;
                end
            end
            if (mv_p) selected_d = (selected_q == 4'd8) ? 4'd0 : selected_q + 4'd1;
            win_mark = line_winner(board_d);
            for (int i = 0; i < NUM_CELLS; i++) begin
                if (board_d[2*i +: 2] == EMPTY) board_full = 1'b0;
            end
            if (win_mark != EMPTY) begin
                state_d  = WIN;
                winner_d = win_mark;
                player_d = player_q;
            end else if (board_full) begin
                state_d = DRAW;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            selected_q <= 4'd0;
            board_q    <= '0;
            player_q   <= 1'b0;
            secs_q     <= SECS_RELOAD;
            presc_q    <= '0;
            state_q    <= PLAY;
            winner_q   <= 2'b00;
            f30_q      <= 1'b0;
        end else begin
            selected_q <= selected_d;
            board_q    <= board_d;
            player_q   <= player_d;
            secs_q     <= secs_d;
            presc_q    <= presc_d;
            state_q    <= state_d;
            winner_q   <= winner_d;
            f30_q      <= f30_d;
        end
    end

    assign selected     = selected_q;
    assign board        = board_q;
    assign player       = player_q;
    assign seconds_left = secs_q;
    assign winner       = winner_q;
    assign finish_30sec = f30_q;
    assign counting     = (state_q == PLAY);
    assign finish       = (state_q == WIN) || (state_q == DRAW);

endmodule
